pingpong_bank_buffer: RTL and testbench

PINGPONG_BANK_BUFFER -- requirements
Module: pingpong_bank_buffer

---
 rtl/pingpong_bank_buffer_if.sv | 32 +++
 rtl/pingpong_bank_buffer.sv | 175 +++++++++++++++++
 tb/tb_pingpong_bank_buffer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pingpong_bank_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : pingpong_bank_buffer_if
// Description : Write/read handshake bundle for the ping-pong bank buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pingpong_bank_buffer_if #(
    parameter int BANK_COUNT = 6,
    parameter int WR_WIDTH   = 32,
    parameter int RD_WIDTH   = 8
);
    logic                             I_wr_valid;
    logic [BANK_COUNT*WR_WIDTH-1:0]   I_wr_data;
    logic                             I_wr_last;
    logic                             O_wr_ready;
    logic                             O_rd_valid;
    logic                             I_rd_ready;
    logic [BANK_COUNT*RD_WIDTH-1:0]   O_rd_data;
    logic                             O_rd_last;
    logic [15:0]                      O_drop_count;

    modport master (
        output I_wr_valid, I_wr_data, I_wr_last, I_rd_ready,
        input  O_wr_ready, O_rd_valid, O_rd_data, O_rd_last, O_drop_count
    );

    modport slave (
        input  I_wr_valid, I_wr_data, I_wr_last, I_rd_ready,
        output O_wr_ready, O_rd_valid, O_rd_data, O_rd_last, O_drop_count
    );
endinterface
`default_nettype wire

// File: rtl/pingpong_bank_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pingpong_bank_buffer
// Description : Two-page multi-bank buffer; one page fills while the other
//               streams out in narrower slices through a 2-entry output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module pingpong_bank_buffer #(
    parameter int BANK_COUNT     = 6,
    parameter int WORDS_PER_PAGE = 563,
    parameter int WR_WIDTH       = 32,
    parameter int RD_WIDTH       = 8
) (
    input  wire logic             I_clk,
    input  wire logic             I_reset,
    pingpong_bank_buffer_if.slave bus
);
    localparam int RATIO     = WR_WIDTH / RD_WIDTH;
    localparam int SHIFT     = $clog2(RATIO);
    localparam int SEL_W     = (SHIFT > 0) ? SHIFT : 1;
    localparam int WA_W      = $clog2(WORDS_PER_PAGE + 1);
    localparam int MEM_DEPTH = 2 * WORDS_PER_PAGE;
    localparam int MEM_AW    = $clog2(MEM_DEPTH);
    localparam int BEAT_W    = $clog2(WORDS_PER_PAGE * RATIO + 1);
    localparam int WBUS      = BANK_COUNT * WR_WIDTH;
    localparam int RBUS      = BANK_COUNT * RD_WIDTH;

    typedef enum logic [0:0] {FILL = 1'b0, FULL = 1'b1} wr_state_t;
    typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} rd_state_t;

    logic [WBUS-1:0]   mem_q [MEM_DEPTH];
    wr_state_t         wr_state_q;
    rd_state_t         rd_state_q;
    logic [WA_W-1:0]   wa_q;
    logic              wr_page_q;
    logic [WA_W-1:0]   rd_len_q;
    logic [BEAT_W-1:0] rd_beat_q;
    logic              issue_done_q;
    logic              pipe_v_q;
    logic              pipe_last_q;
    logic [SEL_W-1:0]  pipe_sel_q;
    logic [WBUS-1:0]   rd_word_q;
    logic              buf0_v_q, buf0_last_q, buf1_v_q, buf1_last_q;
    logic [RBUS-1:0]   buf0_data_q, buf1_data_q;
    logic [15:0]       drop_q;

    logic              wr_ready, wr_fire, wr_commit, swap, pop, issue, beat_last;
    logic [BEAT_W-1:0] rd_total;
    logic [1:0]        occupancy;
    logic [MEM_AW-1:0] wr_addr, rd_addr;
    logic [SEL_W-1:0]  pipe_sel_d;
    logic [RBUS-1:0]   push_data;

    assign wr_ready  = (wr_state_q == FILL);
    assign wr_fire   = bus.I_wr_valid && wr_ready;
    assign wr_commit = (wr_fire && (wa_q == WA_W'(WORDS_PER_PAGE - 1)))
                    || (wr_ready && bus.I_wr_last && (wr_fire || (wa_q != '0)));
    assign swap      = (wr_state_q == FULL) && (rd_state_q == IDLE);
    assign pop       = buf0_v_q && bus.I_rd_ready;

    // Credit covers both buffer entries plus the word in flight from memory.
    assign occupancy = 2'(buf0_v_q) + 2'(buf1_v_q) + 2'(pipe_v_q);
    assign rd_total  = BEAT_W'(rd_len_q) << SHIFT;
    assign beat_last = (rd_beat_q == (rd_total - BEAT_W'(1)));
    assign issue     = (rd_state_q == STREAM) && !issue_done_q
                    && ((occupancy - 2'(pop)) < 2'd2);

    assign wr_addr    = MEM_AW'(wa_q) + (wr_page_q ? MEM_AW'(WORDS_PER_PAGE) : '0);
    assign rd_addr    = MEM_AW'(rd_beat_q >> SHIFT) + (!wr_page_q ? MEM_AW'(WORDS_PER_PAGE) : '0);
    assign pipe_sel_d = (RATIO > 1) ? rd_beat_q[SEL_W-1:0] : '0;

    for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
        assign push_data[b*RD_WIDTH +: RD_WIDTH] =
            rd_word_q[b*WR_WIDTH + int'(pipe_sel_q)*RD_WIDTH +: RD_WIDTH];
    end

    always_ff @(posedge I_clk) begin
        if (wr_fire) begin
            mem_q[wr_addr] <= bus.I_wr_data;
        end
        if (issue) begin
            rd_word_q <= mem_q[rd_addr];
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            wr_state_q   <= FILL;
            rd_state_q   <= IDLE;
            wa_q         <= '0;
            wr_page_q    <= 1'b0;
            rd_len_q     <= '0;
            rd_beat_q    <= '0;
            issue_done_q <= 1'b0;
            pipe_v_q     <= 1'b0;
            pipe_last_q  <= 1'b0;
            pipe_sel_q   <= '0;
            buf0_v_q     <= 1'b0;
            buf0_last_q  <= 1'b0;
            buf0_data_q  <= '0;
            buf1_v_q     <= 1'b0;
            buf1_last_q  <= 1'b0;
            buf1_data_q  <= '0;
            drop_q       <= '0;
        end else begin
            if (wr_fire) begin
                wa_q <= wa_q + WA_W'(1);
            end
            if (wr_commit) begin
                wr_state_q <= FULL;
            end
            if (swap) begin
                wr_state_q   <= FILL;
                wa_q         <= '0;
                wr_page_q    <= ~wr_page_q;
                rd_len_q     <= wa_q;
                rd_state_q   <= STREAM;
                rd_beat_q    <= '0;
                issue_done_q <= 1'b0;
            end

            pipe_v_q <= issue;
            if (issue) begin
                pipe_sel_q  <= pipe_sel_d;
                pipe_last_q <= beat_last;
                rd_beat_q   <= rd_beat_q + BEAT_W'(1);
                if (beat_last) begin
                    issue_done_q <= 1'b1;
                end
            end

            if (pop) begin
                if (buf1_v_q) begin
                    buf0_data_q <= buf1_data_q;
                    buf0_last_q <= buf1_last_q;
                    buf1_v_q    <= pipe_v_q;
                    buf1_last_q <= pipe_v_q && pipe_last_q;
                    if (pipe_v_q) begin
                        buf1_data_q <= push_data;
                    end
                end else begin
                    buf0_v_q    <= pipe_v_q;
                    buf0_last_q <= pipe_v_q && pipe_last_q;
                    if (pipe_v_q) begin
                        buf0_data_q <= push_data;
                    end
                end
                if (buf0_last_q) begin
                    rd_state_q <= IDLE;
                end
            end else if (pipe_v_q) begin
                if (!buf0_v_q) begin
                    buf0_v_q    <= 1'b1;
                    buf0_last_q <= pipe_last_q;
                    buf0_data_q <= push_data;
                end else begin
                    buf1_v_q    <= 1'b1;
                    buf1_last_q <= pipe_last_q;
                    buf1_data_q <= push_data;
                end
            end

            if (bus.I_wr_valid && !wr_ready && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    assign bus.O_wr_ready   = wr_ready;
    assign bus.O_rd_valid   = buf0_v_q;
    assign bus.O_rd_data    = buf0_data_q;
    assign bus.O_rd_last    = buf0_last_q;
    assign bus.O_drop_count = drop_q;
endmodule
`default_nettype wire

// File: tb/tb_pingpong_bank_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pingpong_bank_buffer
// Description : Directed self-checking bench for pingpong_bank_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pingpong_bank_buffer;
    localparam int BANK_COUNT     = 2;
    localparam int WORDS_PER_PAGE = 4;
    localparam int WR_WIDTH       = 32;
    localparam int RD_WIDTH       = 8;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    pingpong_bank_buffer_if #(
        .BANK_COUNT (BANK_COUNT),
        .WR_WIDTH   (WR_WIDTH),
        .RD_WIDTH   (RD_WIDTH)
    ) bus ();

    pingpong_bank_buffer #(
        .BANK_COUNT     (BANK_COUNT),
        .WORDS_PER_PAGE (WORDS_PER_PAGE),
        .WR_WIDTH       (WR_WIDTH),
        .RD_WIDTH       (RD_WIDTH)
    ) u_dut (
        .I_clk   (clk),
        .I_reset (rst),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Page seed pg: bank0 byte j of word i is pg*16+4*i+j, bank1 is its inverse.
    function automatic logic [63:0] page_word(input int pg, input int i);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'(pg*16 + 4*i + j);
        return {~w, w};
    endfunction

    function automatic logic [15:0] exp_beat(input int pg, input int k);
        logic [7:0] v;
        v = 8'(pg*16 + k);
        return {~v, v};
    endfunction

    task automatic write_words(input int pg, input int n, input bit last);
        for (int i = 0; i < n; i++) begin
            check("wr_ready_before_write", bus.O_wr_ready, 1);
            bus.I_wr_valid = 1'b1;
            bus.I_wr_data  = page_word(pg, i);
            bus.I_wr_last  = last && (i == n - 1);
            tick();
        end
        bus.I_wr_valid = 1'b0;
        bus.I_wr_last  = 1'b0;
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating.
    task automatic read_page(input int pg, input int nbeats, input int mode,
                             input bit full_hold, input int stop_at);
        int         got;
        int         phase;
        bit         held;
        logic [16:0] held_val;
        got = 0;
        phase = 0;
        held = 1'b0;
        held_val = '0;
        for (int cyc = 0; cyc < 300 && got < stop_at; cyc++) begin
            bus.I_rd_ready = (mode == 0) ? 1'b1 : ((phase % 3) == 0);
            phase++;
            if (held) begin
                check("stall_valid", bus.O_rd_valid, 1);
                check("stall_hold", {bus.O_rd_last, bus.O_rd_data}, held_val);
            end
            if (full_hold) check("wr_full_hold", bus.O_wr_ready, 0);
            if (mode == 0 && got > 0) check("no_gap", bus.O_rd_valid, 1);
            if (bus.O_rd_valid && bus.I_rd_ready) begin
                check("rd_data", bus.O_rd_data, exp_beat(pg, got));
                check("rd_last", bus.O_rd_last, (got == nbeats - 1));
                got++;
            end
            held     = bus.O_rd_valid && !bus.I_rd_ready;
            held_val = {bus.O_rd_last, bus.O_rd_data};
            tick();
        end
        check("rd_count", got, stop_at);
    endtask

    initial begin
        int seen;
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.I_wr_valid = 1'b0;
        bus.I_wr_data  = '0;
        bus.I_wr_last  = 1'b0;
        bus.I_rd_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_wr_ready", bus.O_wr_ready, 1);
        check("rst_rd_valid", bus.O_rd_valid, 0);
        check("rst_rd_last", bus.O_rd_last, 0);
        check("rst_rd_data", bus.O_rd_data, 0);
        check("rst_drop", bus.O_drop_count, 0);

        // Full page, continuous readout, swap latency
        bus.I_rd_ready = 1'b1;
        write_words(0, 4, 1'b0);
        check("full_wr_ready_low", bus.O_wr_ready, 0);
        tick();
        check("swap_wr_ready_high", bus.O_wr_ready, 1);
        check("swap_rd_valid0", bus.O_rd_valid, 0);
        tick();
        check("lat_rd_valid1", bus.O_rd_valid, 0);
        tick();
        check("lat_rd_valid2", bus.O_rd_valid, 1);
        read_page(0, 16, 0, 1'b0, 16);

        // Commit with nothing stored does nothing
        bus.I_wr_last = 1'b1;
        tick();
        bus.I_wr_last = 1'b0;
        tick();
        tick();
        check("zero_last_wr_ready", bus.O_wr_ready, 1);
        check("zero_last_rd_valid", bus.O_rd_valid, 0);

        // Partial page: commit with the second word
        write_words(1, 2, 1'b1);
        check("partial_full", bus.O_wr_ready, 0);
        read_page(1, 8, 0, 1'b0, 8);

        // Backpressure
        write_words(2, 4, 1'b0);
        read_page(2, 16, 1, 1'b0, 16);

        // Ping-pong with a stalled reader
        bus.I_rd_ready = 1'b0;
        write_words(3, 4, 1'b0);
        tick();
        write_words(4, 4, 1'b0);
        check("pp_full", bus.O_wr_ready, 0);
        tick();
        tick();
        check("pp_full_stalled", bus.O_wr_ready, 0);
        check("pp_stall_data", bus.O_rd_data, 16'hCF30);
        read_page(3, 16, 0, 1'b1, 16);
        check("pp_full_after_last", bus.O_wr_ready, 0);
        tick();
        check("pp_swap_next", bus.O_wr_ready, 1);
        read_page(4, 16, 0, 1'b0, 16);

        // Drops while the writer is full
        bus.I_rd_ready = 1'b0;
        write_words(5, 4, 1'b0);
        tick();
        write_words(6, 4, 1'b0);
        check("drop_full", bus.O_wr_ready, 0);
        bus.I_wr_valid = 1'b1;
        repeat (3) tick();
        bus.I_wr_valid = 1'b0;
        check("drop_3", bus.O_drop_count, 3);
        bus.I_wr_valid = 1'b1;
        repeat (70000) tick();
        bus.I_wr_valid = 1'b0;
        check("drop_sat", bus.O_drop_count, 16'hFFFF);

        // Reset mid-stream after five read words
        read_page(5, 16, 0, 1'b1, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_rd_valid", bus.O_rd_valid, 0);
        check("mid_rst_wr_ready", bus.O_wr_ready, 1);
        check("mid_rst_drop", bus.O_drop_count, 0);
        check("mid_rst_rd_data", bus.O_rd_data, 0);
        seen = 0;
        bus.I_rd_ready = 1'b1;
        repeat (10) begin
            if (bus.O_rd_valid) seen++;
            tick();
        end
        check("mid_rst_no_stale", seen, 0);
        write_words(7, 1, 1'b1);
        read_page(7, 4, 0, 1'b0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
